// File: rtl/frame_tick_pkg.sv
// Shared types and constants for the frame tick engine.
// Holds the FSM state encoding, the advance-mode encoding and the period floor.
package frame_tick_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_COUNT   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_t;

  localparam logic MODE_FREE  = 1'b0;
  localparam logic MODE_HOLD  = 1'b1;
  localparam int   MIN_PERIOD = 2;

endpackage

// File: rtl/frame_period_counter.sv
// Frame period counter: a shadow period written by software and an active period used for counting.
// The active period follows the shadow only when a frame starts, so a new period applies to the following frame.
module frame_period_counter
  import frame_tick_pkg::*;
#(
  parameter int CNT_WIDTH      = 21,
  parameter int DEFAULT_PERIOD = 1666667
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 period_load,
  input  logic                 reload,
  input  logic                 advance,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 terminal
);

  localparam logic [CNT_WIDTH-1:0] DEFAULT_P = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] MIN_P     = CNT_WIDTH'(MIN_PERIOD);

  logic [CNT_WIDTH-1:0] shadow_reg;
  logic [CNT_WIDTH-1:0] period_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= DEFAULT_P;
      period_reg <= DEFAULT_P;
      counter    <= '0;
    end else begin
      if (period_load)
        shadow_reg <= (period_in < MIN_P) ? MIN_P : period_in;
      // reload takes the pre-load shadow value; a coincident load lands one frame later
      if (reload) begin
        period_reg <= shadow_reg;
        counter    <= '0;
      end else if (advance) begin
        counter <= counter + CNT_WIDTH'(1);
      end
    end
  end

  // The advance cycle itself is the last cycle of the frame, hence period-2.
  assign terminal = (counter == period_reg - MIN_P);

endmodule

// File: rtl/frame_tick_engine.sv
// Frame-advance generator: programmable period, free-run or held ticks, pause and single step,
// frame counting and overrun detection for unacknowledged free-run ticks.
module frame_tick_engine
  import frame_tick_pkg::*;
#(
  parameter int CNT_WIDTH      = 21,
  parameter int DEFAULT_PERIOD = 1666667,
  parameter int FRAME_W        = 16,
  parameter int DROP_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 period_load,
  input  logic                 ack,
  input  logic                 step,
  input  logic                 clr_status,
  output logic                 tick,
  output logic [FRAME_W-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0] phase,
  output logic                 overrun,
  output logic [DROP_W-1:0]    drop_count
);

  state_t state_reg;
  logic   mode_reg;
  logic   pending_reg;
  logic   terminal;
  logic   enter_adv;
  logic   count_inc;
  logic   free_issue;
  logic   adv_done;
  logic   overrun_evt;

  frame_period_counter #(
    .CNT_WIDTH      (CNT_WIDTH),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .period_in   (period_in),
    .period_load (period_load),
    .reload      (enter_adv),
    .advance     (count_inc),
    .counter     (phase),
    .terminal    (terminal)
  );

  always_comb begin
    enter_adv = 1'b0;
    count_inc = 1'b0;
    case (state_reg)
      ST_COUNT: begin
        if (enable) begin
          if (terminal) enter_adv = 1'b1;
          else          count_inc = 1'b1;
        end
      end
      ST_PAUSED: enter_adv = !enable && step;
      default: ;
    endcase
  end

  assign tick        = (state_reg == ST_ADVANCE);
  assign free_issue  = tick && (mode_reg != MODE_HOLD);
  assign adv_done    = tick && ((mode_reg == MODE_FREE) || ack);
  assign overrun_evt = free_issue && pending_reg && !ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_COUNT;
      mode_reg    <= MODE_FREE;
      pending_reg <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      drop_count  <= '0;
    end else begin
      case (state_reg)
        ST_PAUSED: begin
          if (enable)         state_reg <= ST_COUNT;
          else if (enter_adv) state_reg <= ST_ADVANCE;
        end
        ST_COUNT: begin
          if (!enable)        state_reg <= ST_PAUSED;
          else if (enter_adv) state_reg <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (adv_done) state_reg <= enable ? ST_COUNT : ST_PAUSED;
        end
        default: state_reg <= ST_COUNT;
      endcase

      if (enter_adv) mode_reg <= mode;
      if (adv_done)  frame_count <= frame_count + FRAME_W'(1);

      // an ack arriving with the new tick is timely, so the new tick stays pending
      if (free_issue) pending_reg <= 1'b1;
      else if (ack)   pending_reg <= 1'b0;

      if (overrun_evt) begin
        overrun <= 1'b1;
        if (clr_status)           drop_count <= DROP_W'(1);
        else if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end else if (clr_status) begin
        overrun    <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_tick_engine.sv
// Directed and randomized bench for frame_tick_engine with a cycle-level behavioural reference.
module tb_frame_tick_engine;
  import frame_tick_pkg::*;

  localparam int CW = 8;
  localparam int DP = 8;
  localparam int FW = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst, enable, mode, period_load, ack, step, clr_status;
  logic [CW-1:0] period_in;
  logic          tick, overrun;
  logic [FW-1:0] frame_count;
  logic [CW-1:0] phase;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_ok = 0, m_paused, m_waiting, m_hold, m_pending, m_overrun;
  int m_phase, m_period, m_shadow, m_frames, m_drops;

  frame_tick_engine #(
    .CNT_WIDTH(CW), .DEFAULT_PERIOD(DP), .FRAME_W(FW), .DROP_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period_in(period_in),
    .period_load(period_load), .ack(ack), .step(step), .clr_status(clr_status),
    .tick(tick), .frame_count(frame_count), .phase(phase), .overrun(overrun),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    m_waiting = 1;
    m_hold    = mode;
    m_phase   = 0;
    m_period  = m_shadow;
  endtask

  task automatic model_step();
    bit issue, done, ovf;
    int nshadow;
    if (rst) begin
      m_paused = 0; m_waiting = 0; m_hold = 0; m_phase = 0;
      m_period = DP; m_shadow = DP; m_frames = 0;
      m_pending = 0; m_overrun = 0; m_drops = 0; m_ok = 1;
      return;
    end
    issue   = m_waiting && !m_hold;
    done    = m_waiting && (!m_hold || ack);
    ovf     = issue && m_pending && !ack;
    nshadow = period_load ? ((int'(period_in) < 2) ? 2 : int'(period_in)) : m_shadow;
    if (m_waiting) begin
      if (done) begin
        m_frames  = (m_frames + 1) % (1 << FW);
        m_waiting = 0;
        m_paused  = !enable;
      end
    end else if (m_paused) begin
      if (enable) m_paused = 0;
      else if (step) start_frame();
    end else if (!enable) begin
      m_paused = 1;
    end else if (m_phase == m_period - 2) begin
      start_frame();
    end else begin
      m_phase++;
    end
    m_shadow = nshadow;
    if (issue) m_pending = 1;
    else if (ack) m_pending = 0;
    if (ovf) begin
      m_overrun = 1;
      m_drops = clr_status ? 1 : ((m_drops == (1 << DW) - 1) ? m_drops : m_drops + 1);
    end else if (clr_status) begin
      m_overrun = 0;
      m_drops = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (m_ok) begin
      chk("tick", tick, m_waiting);
      chk("frame_count", frame_count, m_frames);
      chk("phase", phase, m_phase);
      chk("overrun", overrun, m_overrun);
      chk("drop_count", drop_count, m_drops);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    while (tick !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    if (tick !== 1'b1) chk("tick_timeout", tick, 1);
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    while (phase !== CW'(p) && k < 40) begin
      cyc();
      k++;
    end
    chk("reach_phase", phase, p);
  endtask

  initial begin
    int n, f0;
    rst = 1; enable = 1; mode = MODE_FREE; period_in = '0; period_load = 0;
    ack = 1; step = 0; clr_status = 0;
    run(2);
    chk("reset_tick", tick, 0);
    chk("reset_frames", frame_count, 0);
    rst = 0;

    // free-run with ack tied high
    wait_tick(20, n);  chk("first_tick_latency", n, 7);
    cyc();             chk("free_tick_width", tick, 0);
    wait_tick(20, n);  chk("free_period", n + 1, 8);
    cyc();             chk("free_frames", frame_count, 2);
    chk("free_no_overrun", overrun, 0);
    $display("step free_run done frames=%0d", frame_count);

    // held tick
    mode = MODE_HOLD; ack = 0;
    wait_tick(20, n);
    run(20);           chk("hold_still_high", tick, 1);
    ack = 1; cyc();    chk("hold_release", tick, 0);
    chk("hold_frames", frame_count, 3);
    ack = 0;
    wait_tick(20, n);  chk("hold_next_tick", n, 7);
    ack = 1; cyc(); ack = 0;
    $display("step hold done frames=%0d", frame_count);

    // overrun with no acks
    mode = MODE_FREE;
    wait_tick(20, n); cyc(); chk("first_unacked_ok", overrun, 0);
    wait_tick(20, n); cyc(); chk("overrun_set", overrun, 1);
    chk("drop_one", drop_count, 1);
    wait_tick(20, n); cyc();
    wait_tick(20, n); cyc(); chk("drop_three", drop_count, 3);
    wait_tick(20, n); cyc(); chk("drop_saturate", drop_count, 3);
    clr_status = 1; cyc(); clr_status = 0;
    chk("clr_overrun", overrun, 0);
    chk("clr_drop", drop_count, 0);
    wait_tick(20, n);
    clr_status = 1; cyc(); clr_status = 0;
    chk("clr_vs_set_flag", overrun, 1);
    chk("clr_vs_set_drop", drop_count, 1);
    ack = 1; cyc();
    $display("step overrun done drops=%0d", drop_count);

    // period reload timing and clamping
    wait_phase(3);
    period_in = CW'(12); period_load = 1; cyc(); period_load = 0;
    wait_tick(20, n);  chk("current_frame_keeps_8", n, 3);
    cyc();
    wait_tick(30, n);  chk("next_frame_12", n + 1, 12);
    period_in = CW'(1); period_load = 1; cyc(); period_load = 0;
    wait_tick(30, n);  chk("frame_before_clamp", n + 1, 12);
    cyc();
    wait_tick(10, n);  chk("clamped_period_2", n + 1, 2);
    period_in = CW'(8); period_load = 1; cyc(); period_load = 0;
    wait_tick(10, n); cyc();
    $display("step period done phase=%0d", phase);

    // pause, resume and single step
    wait_phase(4);
    enable = 0; run(10);
    chk("pause_phase_frozen", phase, 4);
    chk("pause_no_tick", tick, 0);
    enable = 1; cyc();
    wait_tick(20, n);  chk("resume_latency", n, 3);
    enable = 0; cyc(); run(3);
    f0 = m_frames;
    step = 1; cyc(); step = 0;
    chk("step_tick", tick, 1);
    cyc();             chk("step_tick_width", tick, 0);
    chk("step_frame", frame_count, (f0 + 1) % (1 << FW));
    run(5);            chk("step_back_paused", tick, 0);
    $display("step pause done frames=%0d", frame_count);

    // reset during a held tick, then enable dropped during a hold wait
    mode = MODE_HOLD; ack = 0; enable = 1;
    wait_tick(20, n);
    run(3);
    rst = 1; cyc(); rst = 0;
    chk("rst_tick", tick, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_phase", phase, 0);
    wait_tick(20, n);  chk("rst_to_count", n, 7);
    enable = 0; run(5); chk("hold_ignores_enable", tick, 1);
    ack = 1; cyc(); ack = 0;
    chk("hold_ack_release", tick, 0);
    run(3);            chk("hold_then_paused", phase, 0);
    $display("step hold_reset done frames=%0d", frame_count);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      ack         = ($urandom_range(0, 9) < 3);
      step        = ($urandom_range(0, 9) == 0);
      clr_status  = ($urandom_range(0, 39) == 0);
      period_load = ($urandom_range(0, 29) == 0);
      period_in   = CW'($urandom_range(0, 15));
      cyc();
    end
    $display("step random done frames=%0d drops=%0d", frame_count, drop_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
